// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial W-bit subtractor (diff = a - b - bin), LSB first, start/done handshake.
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.

module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic [W-1:0]  res;
  logic          br;
  logic [CW-1:0] cnt;

  logic          d;
  logic          br_nxt;
  logic          last;
  logic [W-1:0]  res_nxt;

  // Single full-subtractor cell operating on the current LSBs.
  assign d       = ra[0] ^ rb[0] ^ br;
  assign br_nxt  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
  assign last    = (cnt == CW'(W - 1));
  assign res_nxt = {d, res[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_msb <= a[W-1];
        b_msb <= b[W-1];
      end
      // The final serial bit is the result MSB, so overflow resolves on the same edge as diff.
      if (state == SHIFT && last) begin
        ovf <= (a_msb ^ b_msb) & (d ^ a_msb);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            br  <= bin;
            cnt <= '0;
            res <= '0;
          end
        end
        SHIFT: begin
          ra  <= {1'b0, ra[W-1:1]};
          rb  <= {1'b0, rb[W-1:1]};
          br  <= br_nxt;
          res <= res_nxt;
          // Hold the counter on the last bit so it never wraps.
          if (!last) begin
            cnt <= cnt + 1'b1;
          end else begin
            diff <= res_nxt;
            bout <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (W=8) with timeline model.
// Covers ovf checks when SERIAL_SUB_OVF_EN is defined.

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted op occupies W+1 further edges; result lands on the W-th one.
  logic         m_inflight;
  int           m_n;
  logic [W-1:0] m_diff, q_diff;
  logic         m_bout, q_bout;
  logic         m_ovf, q_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 1'b0;
      m_n        <= 0;
      m_diff     <= '0;
      m_bout     <= 1'b0;
      m_ovf      <= 1'b0;
    end else if (m_inflight) begin
      m_n <= m_n + 1;
      if (m_n + 1 == W) begin
        m_diff <= q_diff;
        m_bout <= q_bout;
        m_ovf  <= q_ovf;
      end
      if (m_n + 1 == W + 1) begin
        m_inflight <= 1'b0;
      end
    end else if (start) begin
      int unsigned full;
      logic [W-1:0] dv;
      full = int'(a) - int'(b) - int'(bin);
      dv   = full[W-1:0];
      m_inflight <= 1'b1;
      m_n        <= 0;
      q_diff     <= dv;
      q_bout     <= (int'(a) < int'(b) + int'(bin));
      q_ovf      <= (a[W-1] ^ b[W-1]) & (dv[W-1] ^ a[W-1]);
    end
  end

  always @(negedge clk) begin
    chk("cmp_ready", ready, !m_inflight);
    chk("cmp_busy",  busy,  m_inflight && (m_n < W));
    chk("cmp_done",  done,  m_inflight && (m_n == W));
    chk("cmp_diff",  diff,  m_diff);
    chk("cmp_bout",  bout,  m_bout);
`ifdef SERIAL_SUB_OVF_EN
    chk("cmp_ovf",   ovf,   m_ovf);
`endif
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input logic [W-1:0] hd, input logic hb);
    int k;
    bit seen;
    k = 0;
    while (!ready && k < 4 * W) begin
      @(negedge clk);
      k++;
    end
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    seen = 0;
    for (k = 1; k <= 4 * W; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      chk("hold_diff", diff, hd);
      chk("hold_bout", bout, hb);
    end
    chk("done_seen", seen, 1);
    chk("latency_edges", k, W);
    chk("lit_diff", diff, ed);
    chk("lit_bout", bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk("lit_ovf", ovf, eo);
`else
    if (eo) begin
    end
`endif
  endtask

  initial begin
    int ready_low;
    int ndone;
    int done_at [2];
    bit counting;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op(8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0, 8'h23, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hDD, 1'b1);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8'hFF, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b0);

    // start held high with fresh operands every cycle
    ready_low = 0; ndone = 0; counting = 1;
    done_at[0] = -1; done_at[1] = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (counting) begin
          if (!ready) ready_low++;
          else counting = 0;
        end
        if (done) begin
          if (ndone == 0) begin
            chk("held_first_diff", diff, 8'h40);
            chk("held_first_bout", bout, 0);
          end else if (ndone == 1) begin
            chk("held_second_diff", diff, 8'h2C);
            chk("held_second_bout", bout, 0);
          end
          if (ndone < 2) done_at[ndone] = i;
          ndone++;
        end
      end
      a = W'(8'h40 + i * 3);
      b = W'(i * 5);
      bin = 1'b0;
      start = (i < 19);
    end
    start = 1'b0;
    chk("held_ready_low", ready_low, 9);
    chk("held_done_count", ndone, 2);
    chk("held_done1_at", done_at[0], 9);
    chk("held_done2_at", done_at[1], 19);

    // reset in the middle of a shift
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_ready_after", ready, 1);

    // back to back: first result holds until second done
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
